// File: rtl/layer_sequencer_pkg.sv
// rtl/layer_sequencer_pkg.sv - shared state encoding and result packing helpers for layer_sequencer
package layer_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LDW  = 3'd2,
        ST_WTW  = 3'd3,
        ST_STR  = 3'd4,
        ST_WTS  = 3'd5,
        ST_CAP  = 3'd6,
        ST_FIN  = 3'd7
    } seq_state_t;

    // Result word always carries four accumulator lanes.
    localparam int N_LANES = 4;

    // Low bit position of a lane inside the packed result word.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/seq_wait_guard.sv
// rtl/seq_wait_guard.sv - guard cycle, busy-low release and optional watchdog (SEQ_TIMEOUT_EN) for the wait states
module seq_wait_guard
`ifdef SEQ_TIMEOUT_EN
#(
    parameter int TMO_W = 10
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic busy,
    output logic go,
    output logic timeout
);

    logic armed;

    // Armed from the second cycle of a wait state on; the two wait states are
    // never back to back, so dropping 'active' re-creates the guard cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            armed <= 1'b0;
        end else begin
            armed <= active;
        end
    end

    assign go = active && armed && !busy;

`ifdef SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] busy_cnt;

    // Count busy cycles inside the current wait state, restarting on every entry.
    always_ff @(posedge clk) begin
        if (!rst || !active) begin
            busy_cnt <= '0;
        end else if (busy) begin
            busy_cnt <= busy_cnt + TMO_W'(1);
        end
    end

    assign timeout = active && (busy_cnt == {TMO_W{1'b1}});
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - command-driven multi-layer MAC-array sequencer; watchdog under SEQ_TIMEOUT_EN
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int ACC_W   = 16,
    parameter int N_MACS  = 4,
    parameter int LAYER_W = 4
`ifdef SEQ_TIMEOUT_EN
    ,
    parameter int TMO_W   = 10
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [LAYER_W-1:0]         cmd_layers,
    input  logic [2:0]                 cmd_mode,
    output logic                       start_weight,
    output logic                       start_valid_pipeline,
    output logic                       start_layering,
    output logic                       clear_all,
    output logic [2:0]                 mode,
    input  logic                       busy,
    input  logic [ACC_W-1:0]           acc_in_0,
    input  logic [ACC_W-1:0]           acc_in_1,
    input  logic [ACC_W-1:0]           acc_in_2,
    input  logic [ACC_W-1:0]           acc_in_3,
    input  logic [N_MACS-1:0]          valid_in,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [N_LANES*ACC_W-1:0]   res_data,
    output logic [N_MACS-1:0]          res_lanes,
    output logic [LAYER_W-1:0]         res_layer,
    output logic                       done,
    output logic                       err
);

    seq_state_t                 state;
    seq_state_t                 state_next;
    logic [LAYER_W-1:0]         layers;
    logic [LAYER_W-1:0]         layer_idx;
    logic                       last_layer;
    logic                       wait_active;
    logic                       wait_go;
    logic                       wait_timeout;
    logic                       accept;
    logic [N_LANES*ACC_W-1:0]   acc_pack;

    assign accept      = (state == ST_IDLE) && cmd_valid;
    assign last_layer  = (layer_idx == layers - LAYER_W'(1));
    assign wait_active = (state == ST_WTW) || (state == ST_WTS);

    // Pack the four accumulators as {acc3, acc2, acc1, acc0}.
    always_comb begin
        acc_pack = '0;
        acc_pack[lane_lo(0, ACC_W) +: ACC_W] = acc_in_0;
        acc_pack[lane_lo(1, ACC_W) +: ACC_W] = acc_in_1;
        acc_pack[lane_lo(2, ACC_W) +: ACC_W] = acc_in_2;
        acc_pack[lane_lo(3, ACC_W) +: ACC_W] = acc_in_3;
    end

    seq_wait_guard
`ifdef SEQ_TIMEOUT_EN
        #(.TMO_W(TMO_W))
`endif
        u_wait_guard (
            .clk     (clk),
            .rst     (rst),
            .active  (wait_active),
            .busy    (busy),
            .go      (wait_go),
            .timeout (wait_timeout)
        );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore pulse decode; each pulse belongs to exactly one state so they never overlap.
    always_comb begin
        state_next           = state;
        cmd_ready            = 1'b0;
        clear_all            = 1'b0;
        start_weight         = 1'b0;
        start_valid_pipeline = 1'b0;
        start_layering       = 1'b0;
        res_valid            = 1'b0;
        done                 = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = (cmd_layers == '0) ? ST_FIN : ST_CLR;
                end
            end
            ST_CLR: begin
                clear_all  = 1'b1;
                state_next = ST_LDW;
            end
            ST_LDW: begin
                start_weight = 1'b1;
                state_next   = ST_WTW;
            end
            ST_WTW: begin
                if (wait_timeout) begin
                    state_next = ST_FIN;
                end else if (wait_go) begin
                    state_next = ST_STR;
                end
            end
            ST_STR: begin
                if (layer_idx == '0) begin
                    start_valid_pipeline = 1'b1;
                end else begin
                    start_layering = 1'b1;
                end
                state_next = ST_WTS;
            end
            ST_WTS: begin
                if (wait_timeout) begin
                    state_next = ST_FIN;
                end else if (wait_go) begin
                    state_next = ST_CAP;
                end
            end
            ST_CAP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = last_layer ? ST_FIN : ST_CLR;
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Command latch, layer index, lane capture and result snapshot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode      <= '0;
            layers    <= '0;
            layer_idx <= '0;
            res_data  <= '0;
            res_lanes <= '0;
            res_layer <= '0;
        end else begin
            if (accept) begin
                mode      <= cmd_mode;
                layers    <= cmd_layers;
                layer_idx <= '0;
            end
            if (state == ST_CLR) begin
                res_lanes <= '0;
            end else if ((state == ST_STR) || (state == ST_WTS)) begin
                res_lanes <= res_lanes | valid_in;
            end
            if ((state == ST_WTS) && (state_next == ST_CAP)) begin
                res_data  <= acc_pack;
                res_layer <= layer_idx;
            end
            if ((state == ST_CAP) && res_ready && !last_layer) begin
                layer_idx <= layer_idx + LAYER_W'(1);
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic err_q;

    // Sticky watchdog flag, cleared when the next command is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (wait_timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - table-driven self-checking bench for layer_sequencer
module tb_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_layers;
    logic [2:0]  cmd_mode;
    logic        start_weight;
    logic        start_valid_pipeline;
    logic        start_layering;
    logic        clear_all;
    logic [2:0]  mode;
    logic        busy;
    logic [15:0] acc_in_0, acc_in_1, acc_in_2, acc_in_3;
    logic [3:0]  valid_in;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic [3:0]  res_lanes;
    logic [3:0]  res_layer;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    layer_sequencer dut (
        .clk                  (clk),
        .rst                  (rst),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_layers           (cmd_layers),
        .cmd_mode             (cmd_mode),
        .start_weight         (start_weight),
        .start_valid_pipeline (start_valid_pipeline),
        .start_layering       (start_layering),
        .clear_all            (clear_all),
        .mode                 (mode),
        .busy                 (busy),
        .acc_in_0             (acc_in_0),
        .acc_in_1             (acc_in_1),
        .acc_in_2             (acc_in_2),
        .acc_in_3             (acc_in_3),
        .valid_in             (valid_in),
        .res_valid            (res_valid),
        .res_ready            (res_ready),
        .res_data             (res_data),
        .res_lanes            (res_lanes),
        .res_layer            (res_layer),
        .done                 (done),
        .err                  (err)
    );

    typedef struct {
        logic [3:0]  layers;
        logic [2:0]  mode;
        int          busy_len;
        int          ready_wait;
        logic [15:0] base;
        logic [3:0]  lanes;
        int          exp_clr;
        int          exp_svp;
        int          exp_sl;
    } vec_t;

    vec_t vecs[6];

    int checks   = 0;
    int failures = 0;

    int          cyc = 0;
    int          busy_len = 0;
    int          busy_left = 0;
    bit          force_busy = 1'b0;
    int          cur_layer = 0;
    logic [15:0] cur_base = '0;
    logic [3:0]  cur_lanes = '0;
    logic [2:0]  cur_mode = '0;
    bit          stream_step = 1'b0;
    int          np;
    int          n_clr, n_sw, n_svp, n_sl, n_done, n_res, n_overlap;
    int          accept_cyc, done_cyc, hs_cyc;
    int          ev_q[$];
    logic [63:0] prev_data;
    bit          prev_hold = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] acc_val(input int l, input int k);
        return cur_base + 16'(l * 256 + k);
    endfunction

    function automatic logic [63:0] exp_data(input int l);
        return {acc_val(l, 3), acc_val(l, 2), acc_val(l, 1), acc_val(l, 0)};
    endfunction

    function automatic logic [3:0] lane_bit(input int l);
        return 4'(1 << (l % 4));
    endfunction

    // Subsystem model and monitor: busy after each start, per-layer acc/valid stimulus, pulse and result checks.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            busy_left   = 0;
            busy        = force_busy;
            valid_in    = '0;
            prev_hold   = 1'b0;
            stream_step = 1'b0;
        end else begin
            np = int'(clear_all) + int'(start_weight) + int'(start_valid_pipeline) + int'(start_layering);
            if (np > 1) n_overlap++;
            if (cmd_valid && cmd_ready) accept_cyc = cyc;
            if (clear_all) begin
                n_clr++;
                ev_q.push_back(1);
                valid_in = '0;
            end
            if (start_weight) begin
                n_sw++;
                ev_q.push_back(2);
            end
            if (start_valid_pipeline || start_layering) begin
                if (start_valid_pipeline) begin
                    n_svp++;
                    ev_q.push_back(3);
                    cur_layer = 0;
                end else begin
                    n_sl++;
                    ev_q.push_back(4);
                    cur_layer++;
                end
                acc_in_0    = acc_val(cur_layer, 0);
                acc_in_1    = acc_val(cur_layer, 1);
                acc_in_2    = acc_val(cur_layer, 2);
                acc_in_3    = acc_val(cur_layer, 3);
                valid_in    = cur_lanes;
                stream_step = 1'b1;
            end else if (stream_step) begin
                valid_in    = lane_bit(cur_layer);
                stream_step = 1'b0;
            end
            if (start_weight || start_valid_pipeline || start_layering) busy_left = busy_len;
            busy = force_busy || (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (res_valid) begin
                check("cap_quiet", 64'(np), 64'd0);
                if (prev_hold) check("bp_stable", res_data, prev_data);
                prev_hold = !res_ready;
                prev_data = res_data;
            end else begin
                prev_hold = 1'b0;
            end
            if (res_valid && res_ready) begin
                check($sformatf("res_data_l%0d", n_res), res_data, exp_data(n_res));
                check($sformatf("res_layer_l%0d", n_res), 64'(res_layer), 64'(n_res));
                check($sformatf("res_lanes_l%0d", n_res), 64'(res_lanes), 64'(cur_lanes | lane_bit(n_res)));
                check("mode_held", 64'(mode), 64'(cur_mode));
                n_res++;
                hs_cyc = cyc;
            end
        end
    end

    task automatic clear_counts();
        n_clr = 0; n_sw = 0; n_svp = 0; n_sl = 0; n_done = 0; n_res = 0; n_overlap = 0;
        accept_cyc = -1; done_cyc = -1; hs_cyc = -1;
        ev_q.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_pulses"}, 64'({clear_all, start_weight, start_valid_pipeline, start_layering}), 64'd0);
        check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_mode"}, 64'(mode), 64'd0);
        check({tag, "_res_data"}, res_data, 64'd0);
        check({tag, "_res_lanes_layer"}, 64'({res_lanes, res_layer}), 64'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int t;
        int hold;
        int bad;
        int exp_ev[$];
        string tag;
        tag = $sformatf("v%0d", idx);
        cur_base  = v.base;
        cur_lanes = v.lanes;
        cur_mode  = v.mode;
        busy_len  = v.busy_len;
        clear_counts();
        @(posedge clk); #1;
        check({tag, "_idle_ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid  = 1'b1;
        cmd_layers = v.layers;
        cmd_mode   = v.mode;
        res_ready  = (v.ready_wait == 0);
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        cmd_layers = 4'hf;
        cmd_mode   = 3'd0;
        check({tag, "_ready_drop"}, 64'(cmd_ready), 64'd0);
        t = 0;
        hold = 0;
        while (n_done == 0 && t < 3000) begin
            if (v.ready_wait != 0) begin
                if (res_valid && !res_ready) begin
                    hold++;
                    if (hold > v.ready_wait) res_ready = 1'b1;
                end else begin
                    res_ready = 1'b0;
                    hold = 0;
                end
            end
            @(posedge clk); #1;
            t++;
        end
        check({tag, "_done_seen"}, 64'(n_done), 64'd1);
        res_ready = 1'b0;
        @(posedge clk); #1;
        check({tag, "_done_once"}, 64'(n_done), 64'd1);
        check({tag, "_n_clear"}, 64'(n_clr), 64'(v.exp_clr));
        check({tag, "_n_weight"}, 64'(n_sw), 64'(v.exp_clr));
        check({tag, "_n_svp"}, 64'(n_svp), 64'(v.exp_svp));
        check({tag, "_n_layering"}, 64'(n_sl), 64'(v.exp_sl));
        check({tag, "_n_results"}, 64'(n_res), 64'(v.layers));
        check({tag, "_overlap"}, 64'(n_overlap), 64'd0);
        check({tag, "_end_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_end_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_mode"}, 64'(mode), 64'(v.mode));
        if (v.layers == 4'd0) check({tag, "_done_lat"}, 64'(done_cyc - accept_cyc), 64'd1);
        else                  check({tag, "_done_lat"}, 64'(done_cyc - hs_cyc), 64'd1);
        for (int l = 0; l < int'(v.layers); l++) begin
            exp_ev.push_back(1);
            exp_ev.push_back(2);
            exp_ev.push_back((l == 0) ? 3 : 4);
        end
        bad = 0;
        if (ev_q.size() != exp_ev.size()) bad = 1;
        else for (int i = 0; i < ev_q.size(); i++) if (ev_q[i] != exp_ev[i]) bad = 1;
        check({tag, "_order"}, 64'(bad), 64'd0);
    endtask

    initial begin
        int t;
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_layers = '0;
        cmd_mode   = '0;
        res_ready  = 1'b0;
        busy       = 1'b0;
        valid_in   = '0;
        acc_in_0   = '0; acc_in_1 = '0; acc_in_2 = '0; acc_in_3 = '0;
        clear_counts();

        //          layers mode busy wait base      lanes    clr svp sl
        vecs[0] = '{4'd1,  3'd3, 5,  1,  16'h1000, 4'b0001, 1,  1,  0};
        vecs[1] = '{4'd3,  3'd5, 2,  0,  16'h2000, 4'b1000, 3,  1,  2};
        vecs[2] = '{4'd0,  3'd6, 0,  0,  16'h3000, 4'b1111, 0,  0,  0};
        vecs[3] = '{4'd2,  3'd1, 0,  0,  16'h4000, 4'b0100, 2,  1,  1};
        vecs[4] = '{4'd15, 3'd7, 1,  0,  16'hA000, 4'b0010, 15, 1,  14};
        vecs[5] = '{4'd2,  3'd2, 3,  10, 16'h5000, 4'b0000, 2,  1,  1};

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset while waiting in WTS of layer 1 of a 3-layer command.
        cur_base  = 16'h6000;
        cur_lanes = 4'b0011;
        cur_mode  = 3'd4;
        busy_len  = 6;
        clear_counts();
        res_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd_layers = 4'd3;
        cmd_mode   = 3'd4;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        t = 0;
        while (n_sl == 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("abort_reach_layer1", 64'(n_sl), 64'd1);
        @(posedge clk); #1;
        check("abort_in_wts", 64'({cmd_ready, res_valid, busy}), 64'b001);
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset("abort");
        rst = 1'b1;
        res_ready = 1'b0;
        run_vec(6, vecs[3]);

`ifdef SEQ_TIMEOUT_EN
        // Busy stuck high: watchdog forces FIN with err set and no result.
        force_busy = 1'b1;
        busy_len   = 0;
        clear_counts();
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd_layers = 4'd2;
        cmd_mode   = 3'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        t = 0;
        while (n_done == 0 && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        check("tmo_done", 64'(n_done), 64'd1);
        check("tmo_err", 64'(err), 64'd1);
        check("tmo_no_result", 64'(n_res), 64'd0);
        check("tmo_idle", 64'(cmd_ready), 64'd1);
        force_busy = 1'b0;
        run_vec(7, vecs[0]);
        check("tmo_err_cleared", 64'(err), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
